// File: rtl/mistral_mul_accum_if.sv
// Product-stream in / result-stream out bundle for mistral_mul_accum.
// master: producer+consumer side; slave: the accumulator itself.
interface mistral_mul_accum_if #(
   parameter int unsigned P_WIDTH   = 54,
   parameter int unsigned ACC_WIDTH = 64,
   parameter int unsigned LEN_WIDTH = 8
);
   logic [LEN_WIDTH-1:0] len;
   logic                 in_valid;
   logic                 in_ready;
   logic [P_WIDTH-1:0]   p;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] acc;
   logic                 ovf;

   modport master (
      output len, in_valid, p, out_ready,
      input  in_ready, out_valid, acc, ovf
   );

   modport slave (
      input  len, in_valid, p, out_ready,
      output in_ready, out_valid, acc, ovf
   );
endinterface

// File: rtl/mistral_mul_accum.sv
// Accumulates LEN multiplier products per result and hands the sum downstream with
// valid/ready, optional saturation and a per-result sticky overflow flag.
module mistral_mul_accum #(
   parameter int unsigned P_WIDTH   = 54,
   parameter int unsigned ACC_WIDTH = 64,
   parameter bit          SIGNED    = 1'b1,
   parameter bit          SATURATE  = 1'b0,
   parameter int unsigned LEN_WIDTH = 8
) (
   input logic                i_clk,
   input logic                i_sclr,
   mistral_mul_accum_if.slave io_bus
);

   if (ACC_WIDTH < P_WIDTH) begin : g_width_check
      $error("mistral_mul_accum: ACC_WIDTH must be >= P_WIDTH");
   end

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StHold
   } state_e;

   state_e               r_state;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic [LEN_WIDTH-1:0] r_rem;

   state_e               w_state_d;
   logic [ACC_WIDTH-1:0] w_acc_d;
   logic                 w_ovf_d;
   logic [LEN_WIDTH-1:0] w_rem_d;
   logic                 w_in_ready;
   logic                 w_out_valid;
   logic                 w_first;

   logic [ACC_WIDTH-1:0] w_pext;
   logic [ACC_WIDTH:0]   w_sum_full;
   logic [ACC_WIDTH-1:0] w_sum;
   logic                 w_add_ovf;
   logic [ACC_WIDTH-1:0] w_sat;
   logic [ACC_WIDTH-1:0] w_acc_add;
   logic [LEN_WIDTH-1:0] w_len_m1;

   // Extension and overflow detection for the running sum.
   always_comb begin
      w_pext = {ACC_WIDTH{SIGNED && io_bus.p[P_WIDTH-1]}};
      w_pext[P_WIDTH-1:0] = io_bus.p;

      w_sum_full = {1'b0, r_acc} + {1'b0, w_pext};
      w_sum      = w_sum_full[ACC_WIDTH-1:0];

      if (SIGNED) begin
         w_add_ovf = (r_acc[ACC_WIDTH-1] == w_pext[ACC_WIDTH-1]) &&
                     (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
         // Signed overflow always goes toward the operands' sign: 0111.. or 1000..
         w_sat = {ACC_WIDTH{~r_acc[ACC_WIDTH-1]}};
         w_sat[ACC_WIDTH-1] = r_acc[ACC_WIDTH-1];
      end else begin
         w_add_ovf = w_sum_full[ACC_WIDTH];
         w_sat     = {ACC_WIDTH{1'b1}};
      end

      w_acc_add = (SATURATE && w_add_ovf) ? w_sat : w_sum;
      w_len_m1  = (io_bus.len == '0) ? '0 : io_bus.len - LEN_WIDTH'(1);
   end

   always_comb begin
      w_state_d   = r_state;
      w_acc_d     = r_acc;
      w_ovf_d     = r_ovf;
      w_rem_d     = r_rem;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_first     = 1'b0;

      case (r_state)
         StIdle: begin
            w_in_ready = 1'b1;
            w_first    = io_bus.in_valid;
         end
         StAccum: begin
            w_in_ready = 1'b1;
            if (io_bus.in_valid) begin
               w_acc_d = w_acc_add;
               w_ovf_d = r_ovf | w_add_ovf;
               w_rem_d = r_rem - LEN_WIDTH'(1);
               if (r_rem == LEN_WIDTH'(1)) begin
                  w_state_d = StHold;
               end
            end
         end
         StHold: begin
            w_out_valid = 1'b1;
            w_in_ready  = io_bus.out_ready;
            // A beat arriving with the consume starts the next result without a bubble.
            if (io_bus.out_ready) begin
               if (io_bus.in_valid) begin
                  w_first = 1'b1;
               end else begin
                  w_state_d = StIdle;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_first) begin
         w_acc_d   = w_pext;
         w_ovf_d   = 1'b0;
         w_rem_d   = w_len_m1;
         w_state_d = (w_len_m1 == '0) ? StHold : StAccum;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_sclr) begin
         r_state <= StIdle;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_d;
         r_acc   <= w_acc_d;
         r_ovf   <= w_ovf_d;
         r_rem   <= w_rem_d;
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = w_out_valid;
   assign io_bus.acc       = r_acc;
   assign io_bus.ovf       = r_ovf;

endmodule
